bcd_alu_sequencer: RTL and testbench
====================================

# bcd_alu_sequencer

Multi-cycle arithmetic unit and sequencer for the calculator. It runs between the operand/operator registers and the display multiplexer. When the control FSM issues `execute`, it captures the two signed 3-digit BCD operands and the 2-bit operator, then computes the result in binary. It range-checks the result and converts it back to 3 BCD digits plus a sign, for display on HEX0–HEX3.

## Interface
Parameters:
- `WIDTH`, 20: internal signed binary accumulator width; must be ≥ 20, since 999×999 = 998001.
- `CONV_STEPS`, 10: double-dabble shift count, equal to the magnitude width (999 < 2^10).

Ports:
- `clock`  in  1  system clock (clockmain domain).
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `clear`  in  1  synchronous abort/clear (driven from reset_strobe).
- `execute`  in  1  one-cycle start strobe.
- `op_code`  in  2  operator: 00 add, 01 subtract, 10 multiply, 11 divide.
- `a_bcd1`, `a_bcd10`, `a_bcd100`  in  4 each  operand A digits (ones, tens, hundreds).
- `a_neg`  in  1  operand A sign; 1 = negative.
- `b_bcd1`, `b_bcd10`, `b_bcd100`  in  4 each  operand B digits.
- `b_neg`  in  1  operand B sign.
- `res_bcd1`, `res_bcd10`, `res_bcd100`  out  4 each  result digits.
- `res_neg`  out  1  result sign.
- `error`  out  1  last operation failed: overflow, divide-by-zero, or invalid digit.
- `busy`  out  1  high from the cycle after `execute` is accepted through the DONE state inclusive.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.

## Operation
**Reset value:** all outputs 0; state IDLE.

**IDLE**
- `execute`=1 with `clear`=0: register the operands and `op_code`.
- Operand conversion: A = 100·d100 + 10·d10 + d1, negated if the sign bit is set.
- Any operand digit > 9 flags an invalid-digit error.
- Next state: ARITH for op 00/01, ITER for op 10/11.

**ARITH** (1 cycle)
- Computes A+B or A−B in signed `WIDTH`-bit arithmetic.
- Next state: CHECK.

**ITER** (exactly 10 cycles, counter 0–9)
- Both operations work on magnitudes; result sign = a_neg XOR b_neg.
- Multiply: shift-add, one multiplier bit per cycle, LSB first.
- Divide: restoring division, one quotient bit per cycle. The quotient truncates toward zero and the remainder is discarded.
- Next state: CHECK.

**CHECK** (1 cycle)
- Error conditions:
  - |result| > 999;
  - divide with B = 0 (the iterations still run; the result is ignored);
  - invalid digit.
- On error, go to DONE with digits = 0, `res_neg` = 0, `error` = 1.
- Otherwise, go to CONV.

**CONV** (exactly 10 cycles)
- Double-dabble on the 10-bit magnitude: before each shift, add 3 to any BCD nibble ≥ 5.
- Next state: DONE.

**DONE** (1 cycle)
- Output registers are loaded on entry. `done` = 1 and `busy` = 1 for this cycle.
- Next state: IDLE.

**Sign rules**
- A zero result always has `res_neg` = 0, including −0 from a sign XOR and 0 − 0.

**Output hold behaviour**
- Outputs hold their last values until the next DONE, `clear`, or `reset`.
- They are not disturbed while a new operation is busy.

**Boundary conditions**
- `execute` while `busy` is ignored; no queueing.
- Operand input changes after capture do not affect the operation in flight.
- `clear` in any state, including mid-ITER or mid-CONV:
  - next edge: state IDLE;
  - all outputs 0, no `done` pulse;
  - priority over a simultaneous `execute`.
- `reset` asserted mid-operation forces the reset values immediately (asynchronous). Operation restarts only on a new `execute` after deassertion.

## Timing
- Edge 0 is the edge that samples `execute`=1 in IDLE; `busy` rises after edge 0.
- add/sub:
  - ARITH: cycle 1; CHECK: cycle 2; CONV: cycles 3–12;
  - DONE / `done`: cycle 13.
- mul/div:
  - ITER: cycles 1–10; CHECK: cycle 11; CONV: cycles 12–21;
  - DONE: cycle 22.
- Error path: skips CONV.
  - add/sub: `done` at cycle 3.
  - mul/div: `done` at cycle 12.
- `busy` falls after the DONE cycle.
- A new `execute` is accepted in the first IDLE cycle, which is cycle 14 or 23.
- No combinational path from any input to any output.

## Test plan
- A=123, B=456, op 00, execute → `done` exactly at cycle 13; result 5,7,9; `res_neg`=0; `error`=0.
- A=5, B=12, op 01 → result 7 with `res_neg`=1 at cycle 13. Then A=−0 (a_neg=1, digits 0), B=0, op 01 → result 0 with `res_neg`=0.
- A=25, B=4 with b_neg=1, op 10 → −100 at cycle 22. A=999, B=2, op 10 → `error`=1, digits 0, `done` at cycle 12.
- Divide cases:
  - A=7 with a_neg=1, B=2, op 11 → result 3, `res_neg`=1, cycle 22;
  - A=7, B=0, op 11 → `error`=1 at cycle 12;
  - a_bcd10=4'hA → `error`=1.
- Busy handling: pulse `execute` at cycles 5 and 13 of a multiply → both ignored; a single `done` at cycle 22 with the first result.
- Abort handling:
  - `clear` at ITER cycle 6 → IDLE next edge, outputs 0, no `done`;
  - `reset` asserted mid-CONV → outputs 0 immediately;
  - execute after release → normal 13-cycle add.

Source files
------------

// File: rtl/bcd_alu_sequencer.sv
// bcd_alu_sequencer: multi-cycle signed 3-digit BCD calculator core.
// Captures two BCD operands and an operator on execute, computes the result
// in binary (single-cycle add/sub, 10-step shift-add multiply or restoring
// divide), range-checks it, then converts the magnitude back to BCD with a
// 10-step double-dabble before presenting it for one DONE cycle.
module bcd_alu_sequencer #(
    parameter int WIDTH      = 20,
    parameter int CONV_STEPS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       execute,
    input  logic [1:0] op_code,
    input  logic [3:0] a_bcd1,
    input  logic [3:0] a_bcd10,
    input  logic [3:0] a_bcd100,
    input  logic       a_neg,
    input  logic [3:0] b_bcd1,
    input  logic [3:0] b_bcd10,
    input  logic [3:0] b_bcd100,
    input  logic       b_neg,
    output logic [3:0] res_bcd1,
    output logic [3:0] res_bcd10,
    output logic [3:0] res_bcd100,
    output logic       res_neg,
    output logic       error,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARITH,
        S_ITER,
        S_CHECK,
        S_CONV,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'(CONV_STEPS - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [1:0]        op;
    logic [9:0]        a_mag;
    logic [9:0]        b_mag;
    logic              a_sgn;
    logic              b_sgn;
    logic              bad_digit;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  mcand;
    logic [9:0]        mplier;
    logic [9:0]        rem;
    logic [9:0]        quo;
    logic [9:0]        mag;
    logic [11:0]       bcd;
    logic              res_sign;

    logic [9:0]        a_conv;
    logic [9:0]        b_conv;
    logic              bad_conv;
    logic [WIDTH-1:0]  a_val;
    logic [WIDTH-1:0]  b_val;
    logic [10:0]       rem_shift;
    logic              rem_fits;
    logic [WIDTH-1:0]  chk_mag;
    logic              chk_neg;
    logic              chk_err;
    logic [11:0]       bcd_next;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Convert live operand digits to binary magnitudes and flag non-decimal digits.
    always_comb begin
        a_conv   = {6'd0, a_bcd100} * 10'd100 + {6'd0, a_bcd10} * 10'd10 + {6'd0, a_bcd1};
        b_conv   = {6'd0, b_bcd100} * 10'd100 + {6'd0, b_bcd10} * 10'd10 + {6'd0, b_bcd1};
        bad_conv = (a_bcd1 > 4'd9) | (a_bcd10 > 4'd9) | (a_bcd100 > 4'd9) |
                   (b_bcd1 > 4'd9) | (b_bcd10 > 4'd9) | (b_bcd100 > 4'd9);
    end

    // Signed two's-complement views of the captured operands for add/subtract.
    always_comb begin
        a_val = {{(WIDTH-10){1'b0}}, a_mag};
        b_val = {{(WIDTH-10){1'b0}}, b_mag};
        if (a_sgn) a_val = -a_val;
        if (b_sgn) b_val = -b_val;
    end

    // One restoring-division step: shift the next dividend bit into the remainder.
    always_comb begin
        rem_shift = {rem, quo[9]};
        rem_fits  = rem_shift >= {1'b0, b_mag};
    end

    // Result magnitude, sign and error decision evaluated in CHECK.
    always_comb begin
        chk_mag = '0;
        chk_neg = 1'b0;
        case (op)
            2'b00, 2'b01: begin
                chk_neg = acc[WIDTH-1];
                chk_mag = acc[WIDTH-1] ? -acc : acc;
            end
            2'b10: begin
                chk_neg = a_sgn ^ b_sgn;
                chk_mag = acc;
            end
            default: begin
                chk_neg = a_sgn ^ b_sgn;
                chk_mag = {{(WIDTH-10){1'b0}}, quo};
            end
        endcase
        chk_err = bad_digit | (chk_mag > WIDTH'(999)) | ((op == 2'b11) && (b_mag == 10'd0));
    end

    // Next double-dabble value: adjust nibbles, then shift in the magnitude MSB.
    always_comb begin
        bcd_next = 12'({dabble_adjust(bcd), mag[9]});
    end

    // Sequencer FSM with all datapath registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op         <= '0;
            a_mag      <= '0;
            b_mag      <= '0;
            a_sgn      <= 1'b0;
            b_sgn      <= 1'b0;
            bad_digit  <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            rem        <= '0;
            quo        <= '0;
            mag        <= '0;
            bcd        <= '0;
            res_sign   <= 1'b0;
            res_bcd1   <= '0;
            res_bcd10  <= '0;
            res_bcd100 <= '0;
            res_neg    <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (clear) begin
            state      <= S_IDLE;
            cnt        <= '0;
            res_bcd1   <= '0;
            res_bcd10  <= '0;
            res_bcd100 <= '0;
            res_neg    <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (execute) begin
                        op        <= op_code;
                        a_mag     <= a_conv;
                        b_mag     <= b_conv;
                        a_sgn     <= a_neg;
                        b_sgn     <= b_neg;
                        bad_digit <= bad_conv;
                        acc       <= '0;
                        mcand     <= {{(WIDTH-10){1'b0}}, a_conv};
                        mplier    <= b_conv;
                        rem       <= '0;
                        quo       <= a_conv;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= op_code[1] ? S_ITER : S_ARITH;
                    end
                end
                S_ARITH: begin
                    acc   <= op[0] ? (a_val - b_val) : (a_val + b_val);
                    state <= S_CHECK;
                end
                S_ITER: begin
                    if (op[0]) begin
                        rem <= rem_fits ? 10'(rem_shift - {1'b0, b_mag}) : rem_shift[9:0];
                        quo <= {quo[8:0], rem_fits};
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_STEP) begin
                        cnt   <= '0;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_err) begin
                        res_bcd1   <= '0;
                        res_bcd10  <= '0;
                        res_bcd100 <= '0;
                        res_neg    <= 1'b0;
                        error      <= 1'b1;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        mag      <= chk_mag[9:0];
                        res_sign <= chk_neg && (chk_mag != '0);
                        bcd      <= '0;
                        cnt      <= '0;
                        state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd <= bcd_next;
                    mag <= mag << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_STEP) begin
                        cnt        <= '0;
                        res_bcd1   <= bcd_next[3:0];
                        res_bcd10  <= bcd_next[7:4];
                        res_bcd100 <= bcd_next[11:8];
                        res_neg    <= res_sign;
                        error      <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// tb_bcd_alu_sequencer: directed and randomized checks of bcd_alu_sequencer
// against an integer-arithmetic reference model.
module tb_bcd_alu_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic       execute;
    logic [1:0] op_code;
    logic [3:0] a_bcd1, a_bcd10, a_bcd100;
    logic       a_neg;
    logic [3:0] b_bcd1, b_bcd10, b_bcd100;
    logic       b_neg;
    logic [3:0] res_bcd1, res_bcd10, res_bcd100;
    logic       res_neg;
    logic       error;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    bcd_alu_sequencer #(.WIDTH(20), .CONV_STEPS(10)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .execute    (execute),
        .op_code    (op_code),
        .a_bcd1     (a_bcd1),
        .a_bcd10    (a_bcd10),
        .a_bcd100   (a_bcd100),
        .a_neg      (a_neg),
        .b_bcd1     (b_bcd1),
        .b_bcd10    (b_bcd10),
        .b_bcd100   (b_bcd100),
        .b_neg      (b_neg),
        .res_bcd1   (res_bcd1),
        .res_bcd10  (res_bcd10),
        .res_bcd100 (res_bcd100),
        .res_neg    (res_neg),
        .error      (error),
        .busy       (busy),
        .done       (done)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // Hard time limit so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference result from plain integer arithmetic on the decimal operands.
    task automatic modelOp(input logic [1:0] op,
                           input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0, input logic an,
                           input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0, input logic bn,
                           output int e1, output int e10, output int e100,
                           output int eneg, output int eerr, output int elat);
        int a, b, r, m;
        bit err;
        a = int'(a2) * 100 + int'(a1) * 10 + int'(a0);
        b = int'(b2) * 100 + int'(b1) * 10 + int'(b0);
        if (an) a = -a;
        if (bn) b = -b;
        err = (a2 > 9) || (a1 > 9) || (a0 > 9) || (b2 > 9) || (b1 > 9) || (b0 > 9);
        r = 0;
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: r = a * b;
            default: begin
                if (b == 0) err = 1;
                else r = a / b;
            end
        endcase
        if (r > 999 || r < -999) err = 1;
        if (err) begin
            e1 = 0; e10 = 0; e100 = 0; eneg = 0; eerr = 1;
            elat = (op < 2) ? 3 : 12;
        end else begin
            m = (r < 0) ? -r : r;
            e1 = m % 10; e10 = (m / 10) % 10; e100 = m / 100;
            eneg = (r < 0) ? 1 : 0; eerr = 0;
            elat = (op < 2) ? 13 : 22;
        end
    endtask

    function automatic logic [3:0] randDigit();
        if ($urandom_range(0, 24) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    // Scramble operand inputs so a change after capture would be noticed.
    task automatic scrambleInputs();
        op_code  = 2'($urandom);
        a_bcd1   = 4'($urandom); a_bcd10 = 4'($urandom); a_bcd100 = 4'($urandom);
        b_bcd1   = 4'($urandom); b_bcd10 = 4'($urandom); b_bcd100 = 4'($urandom);
        a_neg    = 1'($urandom); b_neg   = 1'($urandom);
    endtask

    // Start an operation one cycle after the call; returns in cycle 1.
    task automatic startOp(input logic [1:0] op,
                           input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0, input logic an,
                           input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0, input logic bn);
        @(posedge clock); #1;
        op_code = op;
        a_bcd100 = a2; a_bcd10 = a1; a_bcd1 = a0; a_neg = an;
        b_bcd100 = b2; b_bcd10 = b1; b_bcd1 = b0; b_neg = bn;
        execute = 1'b1;
        @(posedge clock); #1;
        execute = 1'b0;
        scrambleInputs();
    endtask

    // Run one operation to completion and compare everything to the model.
    task automatic applyStimulus(input logic [1:0] op,
                                 input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0, input logic an,
                                 input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0, input logic bn,
                                 input bit inject);
        int e1, e10, e100, eneg, eerr, elat;
        int n;
        modelOp(op, a2, a1, a0, an, b2, b1, b0, bn, e1, e10, e100, eneg, eerr, elat);
        startOp(op, a2, a1, a0, an, b2, b1, b0, bn);
        checkOutput("busy_rise", busy, 1);
        n = 1;
        while (!done && n < 40) begin
            execute = inject && (n == 5 || n == 13);
            if (execute) scrambleInputs();
            @(posedge clock); #1;
            n++;
        end
        execute = 1'b0;
        checkOutput("done_seen", done, 1);
        checkOutput("latency", n, elat);
        checkOutput("res_bcd1", res_bcd1, e1);
        checkOutput("res_bcd10", res_bcd10, e10);
        checkOutput("res_bcd100", res_bcd100, e100);
        checkOutput("res_neg", res_neg, eneg);
        checkOutput("error", error, eerr);
        checkOutput("busy_at_done", busy, 1);
        @(posedge clock); #1;
        checkOutput("done_pulse_end", done, 0);
        checkOutput("busy_fall", busy, 0);
        checkOutput("hold_bcd1", res_bcd1, e1);
        checkOutput("hold_error", error, eerr);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_bcd1"}, res_bcd1, 0);
        checkOutput({tag, "_bcd10"}, res_bcd10, 0);
        checkOutput({tag, "_bcd100"}, res_bcd100, 0);
        checkOutput({tag, "_neg"}, res_neg, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    // Main stimulus sequence.
    initial begin
        int dones;
        reset = 1'b1; clear = 1'b0; execute = 1'b0;
        op_code = '0;
        a_bcd1 = '0; a_bcd10 = '0; a_bcd100 = '0; a_neg = 1'b0;
        b_bcd1 = '0; b_bcd10 = '0; b_bcd100 = '0; b_neg = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        $display("[TB] directed cases");
        applyStimulus(2'b00, 4'd1, 4'd2, 4'd3, 1'b0, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
        applyStimulus(2'b01, 4'd0, 4'd0, 4'd5, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);
        applyStimulus(2'b01, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(2'b10, 4'd0, 4'd2, 4'd5, 1'b0, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
        applyStimulus(2'b10, 4'd9, 4'd9, 4'd9, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
        applyStimulus(2'b11, 4'd0, 4'd0, 4'd7, 1'b1, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
        applyStimulus(2'b11, 4'd0, 4'd0, 4'd7, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(2'b00, 4'd0, 4'hA, 4'd1, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        applyStimulus(2'b00, 4'd9, 4'd9, 4'd9, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        applyStimulus(2'b01, 4'd9, 4'd9, 4'd9, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(2'b11, 4'd9, 4'd9, 4'd9, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        applyStimulus(2'b10, 4'd0, 4'd3, 4'd1, 1'b1, 4'd0, 4'd3, 4'd1, 1'b1, 1'b0);

        $display("[TB] execute while busy");
        applyStimulus(2'b10, 4'd0, 4'd1, 4'd2, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 1'b1);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (done || busy) dones++;
        end
        checkOutput("no_queued_op", dones, 0);

        $display("[TB] clear mid-ITER");
        applyStimulus(2'b00, 4'd1, 4'd2, 4'd3, 1'b0, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
        startOp(2'b10, 4'd0, 4'd2, 4'd5, 1'b0, 4'd0, 4'd0, 4'd4, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("held_during_busy", res_bcd100, 5);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        checkAllZero("clear");
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        checkOutput("no_done_after_clear", dones, 0);

        $display("[TB] clear beats execute");
        @(posedge clock); #1;
        clear = 1'b1; execute = 1'b1; op_code = 2'b00; a_bcd1 = 4'd1;
        @(posedge clock); #1;
        clear = 1'b0; execute = 1'b0;
        checkOutput("clear_priority_busy", busy, 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        checkOutput("clear_priority_done", dones, 0);

        $display("[TB] reset mid-CONV");
        applyStimulus(2'b00, 4'd1, 4'd2, 4'd3, 1'b0, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
        startOp(2'b01, 4'd0, 4'd0, 4'd5, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("held_before_reset", res_bcd1, 9);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (done || busy) dones++;
        end
        checkOutput("idle_after_reset", dones, 0);
        applyStimulus(2'b00, 4'd2, 4'd0, 4'd8, 1'b1, 4'd0, 4'd3, 4'd3, 1'b0, 1'b0);

        $display("[TB] randomized cases");
        for (int k = 0; k < 60; k++) begin
            logic [1:0] rop;
            logic [3:0] ra2, ra1, ra0, rb2, rb1, rb0;
            rop = 2'($urandom);
            ra2 = randDigit(); ra1 = randDigit(); ra0 = randDigit();
            rb2 = randDigit(); rb1 = randDigit(); rb0 = randDigit();
            if (rop[1] && $urandom_range(0, 2) != 0) begin
                rb2 = 4'd0;
                if ($urandom_range(0, 1) == 0) rb1 = 4'd0;
            end
            applyStimulus(rop, ra2, ra1, ra0, 1'($urandom), rb2, rb1, rb0, 1'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
